// File: rtl/uart_proc.sv
// Sequenced word processor between the UART RX FIFO and TX FIFO: pop one word,
// transform it by the mode captured at pop time, wait for TX room, then push it.
module uart_proc #(
    parameter int DBIT   = 8,   // must be even so the half-swap splits the word cleanly
    parameter int OFFSET = 1,
    parameter int CNT_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             rx_empty,
    input  logic [DBIT-1:0]  r_data,
    input  logic             tx_full,
    input  logic [1:0]       i_mode,
    input  logic             i_enable,
    output logic             rd_uart,
    output logic             wr_uart,
    output logic [DBIT-1:0]  w_data,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_count,
    output logic [2:0]       dbg_state
);

    // FIFO handshake: rd_uart is a one-cycle pop of the show-ahead head word (only
    // issued after rx_empty=0 was seen in IDLE); wr_uart is a one-cycle push of the
    // stable w_data (only issued after tx_full=0 was seen in PROC or WAIT).

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_PROC  = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_ADD  = 2'b01;
    localparam logic [1:0] MODE_INV  = 2'b10;
    localparam logic [1:0] MODE_SWAP = 2'b11;

    localparam int HALF = DBIT / 2;
    localparam logic [DBIT-1:0] OFFSET_W = DBIT'(OFFSET);

    state_t state;
    state_t state_next;

    logic [DBIT-1:0] operand;
    logic [1:0]      mode;
    logic [DBIT-1:0] result;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rd_uart    = 1'b0;
        wr_uart    = 1'b0;
        o_busy     = 1'b1;
        unique case (state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_enable && !rx_empty) begin
                    state_next = S_READ;
                end
            end
            S_READ: begin
                rd_uart    = 1'b1;
                state_next = S_PROC;
            end
            S_PROC: begin
                state_next = tx_full ? S_WAIT : S_WRITE;
            end
            S_WAIT: begin
                if (!tx_full) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                // The block is the only TX writer, so room seen earlier is still there.
                wr_uart    = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                o_busy     = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        result = operand;
        unique case (mode)
            MODE_PASS: result = operand;
            MODE_ADD:  result = operand + OFFSET_W;
            MODE_INV:  result = ~operand;
            MODE_SWAP: result = {operand[HALF-1:0], operand[DBIT-1:HALF]};
            default:   result = operand;
        endcase
    end

    // Operand and mode are frozen at pop time so later i_mode changes cannot touch the word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            operand <= '0;
            mode    <= MODE_PASS;
            w_data  <= '0;
            o_count <= '0;
        end else begin
            if (state == S_READ) begin
                operand <= r_data;
                mode    <= i_mode;
            end
            if (state == S_PROC) begin
                w_data <= result;
            end
            if (state == S_WRITE) begin
                o_count <= o_count + CNT_W'(1);
            end
        end
    end

    assign dbg_state = state;

endmodule
